// File: rtl/seven_seg_pkg.sv
// Seven-segment glyph encodings, active-high, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [6:0] seven_seg_t;

  localparam seven_seg_t ZERO  = 7'h3F;
  localparam seven_seg_t ONE   = 7'h06;
  localparam seven_seg_t TWO   = 7'h5B;
  localparam seven_seg_t THREE = 7'h4F;
  localparam seven_seg_t FOUR  = 7'h66;
  localparam seven_seg_t FIVE  = 7'h6D;
  localparam seven_seg_t SIX   = 7'h7D;
  localparam seven_seg_t SEVEN = 7'h07;
  localparam seven_seg_t EIGHT = 7'h7F;
  localparam seven_seg_t NINE  = 7'h6F;
  localparam seven_seg_t A     = 7'h77;
  localparam seven_seg_t B     = 7'h7C;
  localparam seven_seg_t C     = 7'h39;
  localparam seven_seg_t D     = 7'h5E;
  localparam seven_seg_t E     = 7'h79;
  localparam seven_seg_t F     = 7'h71;

  // Hex nibble to active-high segment pattern
  function automatic seven_seg_t hex_to_seg(input logic [3:0] hex);
    seven_seg_t seg;
    case (hex)
      4'h0:    seg = ZERO;
      4'h1:    seg = ONE;
      4'h2:    seg = TWO;
      4'h3:    seg = THREE;
      4'h4:    seg = FOUR;
      4'h5:    seg = FIVE;
      4'h6:    seg = SIX;
      4'h7:    seg = SEVEN;
      4'h8:    seg = EIGHT;
      4'h9:    seg = NINE;
      4'hA:    seg = A;
      4'hB:    seg = B;
      4'hC:    seg = C;
      4'hD:    seg = D;
      4'hE:    seg = E;
      default: seg = F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit hex driver for 7-segment displays. Latches a shadow copy of the
// display data and scans one digit per refresh slot, with per-digit decimal point, blank,
// blink, optional leading-zero suppression and an anti-ghosting dead time at slot start.
module seven_seg_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES    = 1000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic                    lz_blank_en_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  // XOR masks turn the active-high internal form into pin polarity
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};
  localparam logic                  DP_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};

  // Shadow registers
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_blink;

  // Scan state
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_blink_on;

  // Registered outputs
  logic [6:0]            r_seg;
  logic                  r_dp_out;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame;

  logic                  w_slot_wrap;
  logic                  w_frame_wrap;
  logic                  w_dead;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_dark;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [6:0]            w_seg_d;
  logic                  w_dp_d;
  logic [NUM_DIGITS-1:0] w_an_d;

  assign w_slot_wrap  = (r_cnt == CNT_MAX);
  assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_MAX);
  assign w_dead       = (32'(r_cnt) < DEAD_CYCLES);
  assign w_onehot     = NUM_DIGITS'(1) << r_idx;

  // Shadow capture, slot/digit/blink counters and frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_dp       <= '0;
      r_blank    <= '0;
      r_blink    <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_blk_cnt  <= '0;
      r_blink_on <= 1'b1;
      r_frame    <= 1'b0;
    end else begin
      if (load_i) begin
        r_data  <= data_i;
        r_dp    <= dp_i;
        r_blank <= blank_i;
        r_blink <= blink_i;
      end
      if (w_slot_wrap) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_frame <= w_frame_wrap;
      if (w_frame_wrap) begin
        if (r_blk_cnt == BLK_MAX) begin
          r_blk_cnt  <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_blk_cnt <= r_blk_cnt + 1'b1;
        end
      end
    end
  end

  // Leading-zero mask: digit k suppressed when it and every digit above it are zero
  always_comb begin
    logic w_zero_above;
    w_lz         = '0;
    w_zero_above = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      w_zero_above = w_zero_above & (r_data[4*k +: 4] == 4'h0);
      w_lz[k]      = lz_blank_en_i & w_zero_above;
    end
  end

  // Select the active digit's nibble, dp and darkness
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_dark   = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_data[4*k +: 4];
        w_dp_sel = r_dp[k];
        w_dark   = r_blank[k] | (r_blink[k] & ~r_blink_on) | w_lz[k];
      end
    end
  end

  // Next output values; dark digits keep their anode but show nothing
  always_comb begin
    w_seg_d = SEG_OFF;
    w_dp_d  = DP_OFF;
    w_an_d  = AN_OFF;
    if (!w_dead) begin
      w_an_d = w_onehot ^ AN_OFF;
      if (!w_dark) begin
        w_seg_d = seven_seg_pkg::hex_to_seg(w_nib) ^ SEG_OFF;
        w_dp_d  = w_dp_sel ^ DP_OFF;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg    <= SEG_OFF;
      r_dp_out <= DP_OFF;
      r_an     <= AN_OFF;
    end else begin
      r_seg    <= w_seg_d;
      r_dp_out <= w_dp_d;
      r_an     <= w_an_d;
    end
  end

  assign seg_o   = r_seg;
  assign dp_o    = r_dp_out;
  assign an_o    = r_an;
  assign frame_o = r_frame;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: 4 digits, 8-cycle slots, 2 dead cycles, 2-frame blink.
// After reset release, cyc counts clock edges; the outputs seen at cyc reflect scan state cyc-1.
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic [3:0]  blink_i = '0;
  logic        lz_blank_en_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  seven_seg_mux #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (8),
    .DEAD_CYCLES   (2),
    .BLINK_FRAMES  (2),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_i),
    .data_i       (data_i),
    .dp_i         (dp_i),
    .blank_i      (blank_i),
    .blink_i      (blink_i),
    .lz_blank_en_i(lz_blank_en_i),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_o      (frame_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    load_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  // Advance until the outputs reflect scan state s
  task automatic goto_slot(input int s);
    while (cyc < s + 1) tick();
  endtask

  task automatic load_now(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                          input logic [3:0] bk);
    data_i  = d;
    dp_i    = dp;
    blank_i = bl;
    blink_i = bk;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an [11] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
    rst = 1'b1;
    tick();
    n_vec++; if (seg_o !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", seg_o); end
    n_vec++; if (an_o !== 4'hF) begin n_err++; $display("FAIL reset_an got %h want f", an_o); end
    n_vec++; if (dp_o !== 1'b1) begin n_err++; $display("FAIL reset_dp got %b want 1", dp_o); end
    n_vec++; if (frame_o !== 1'b0) begin n_err++; $display("FAIL reset_frame got %b want 0", frame_o); end
    repeat (2) tick();
    rst = 1'b0;
    cyc = 0;
    for (int s = 0; s < 11; s++) begin
      goto_slot(s);
      n_vec++;
      if (an_o !== exp_an[s]) begin
        n_err++; $display("FAIL scan_an s=%0d got %h want %h", s, an_o, exp_an[s]);
      end
    end
  endtask

  task automatic test_decode();
    int         ss   [5] = '{2, 8, 10, 18, 26};
    logic [6:0] eseg [5] = '{7'h0E, 7'h7F, 7'h08, 7'h24, 7'h79};
    logic [3:0] ean  [5] = '{4'hE, 4'hF, 4'hD, 4'hB, 4'h7};
    do_reset();
    lz_blank_en_i = 1'b0;
    load_now(16'h12AF, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      goto_slot(ss[i]);
      n_vec++;
      if (seg_o !== eseg[i] || an_o !== ean[i] || dp_o !== 1'b1) begin
        n_err++;
        $display("FAIL decode s=%0d got seg=%h an=%h dp=%b want seg=%h an=%h dp=1",
                 ss[i], seg_o, an_o, dp_o, eseg[i], ean[i]);
      end
    end
    // frame_o high exactly after edges 32 and 64
    while (cyc < 70) begin
      tick();
      n_vec++;
      if (frame_o !== ((cyc == 32) || (cyc == 64))) begin
        n_err++; $display("FAIL frame cyc=%0d got %b", cyc, frame_o);
      end
    end
  endtask

  task automatic test_lz();
    int         ss   [6] = '{2, 10, 18, 26, 50, 58};
    logic [6:0] eseg [6] = '{7'h40, 7'h12, 7'h7F, 7'h40, 7'h40, 7'h7F};
    logic [3:0] ean  [6] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hB, 4'h7};
    logic       elz  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    load_now(16'h0050, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      lz_blank_en_i = elz[i];
      goto_slot(ss[i]);
      n_vec++;
      if (seg_o !== eseg[i] || an_o !== ean[i] || dp_o !== 1'b1) begin
        n_err++;
        $display("FAIL lz s=%0d got seg=%h an=%h dp=%b want seg=%h an=%h dp=1",
                 ss[i], seg_o, an_o, dp_o, eseg[i], ean[i]);
      end
    end
  endtask

  task automatic test_lz_dp();
    int         ss   [4] = '{2, 10, 18, 26};
    logic [6:0] eseg [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] ean  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic       edp  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    lz_blank_en_i = 1'b1;
    load_now(16'h0000, 4'b0011, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      goto_slot(ss[i]);
      n_vec++;
      if (seg_o !== eseg[i] || an_o !== ean[i] || dp_o !== edp[i]) begin
        n_err++;
        $display("FAIL lz_dp s=%0d got seg=%h an=%h dp=%b want seg=%h an=%h dp=%b",
                 ss[i], seg_o, an_o, dp_o, eseg[i], ean[i], edp[i]);
      end
    end
  endtask

  task automatic test_blank();
    do_reset();
    lz_blank_en_i = 1'b0;
    load_now(16'h12AF, 4'b0100, 4'b0100, 4'h0);
    goto_slot(10);
    n_vec++;
    if (seg_o !== 7'h08 || an_o !== 4'hD || dp_o !== 1'b1) begin
      n_err++; $display("FAIL blank_d1 got seg=%h an=%h dp=%b want 08 d 1", seg_o, an_o, dp_o);
    end
    goto_slot(18);
    n_vec++;
    if (seg_o !== 7'h7F || an_o !== 4'hB || dp_o !== 1'b1) begin
      n_err++; $display("FAIL blank_d2 got seg=%h an=%h dp=%b want 7f b 1", seg_o, an_o, dp_o);
    end
  endtask

  task automatic test_blink();
    int         ss   [6] = '{10, 42, 66, 74, 106, 138};
    logic [6:0] eseg [6] = '{7'h08, 7'h08, 7'h0E, 7'h7F, 7'h7F, 7'h08};
    logic [3:0] ean  [6] = '{4'hD, 4'hD, 4'hE, 4'hD, 4'hD, 4'hD};
    do_reset();
    lz_blank_en_i = 1'b0;
    load_now(16'h12AF, 4'h0, 4'h0, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      goto_slot(ss[i]);
      n_vec++;
      if (seg_o !== eseg[i] || an_o !== ean[i]) begin
        n_err++;
        $display("FAIL blink s=%0d got seg=%h an=%h want seg=%h an=%h",
                 ss[i], seg_o, an_o, eseg[i], ean[i]);
      end
    end
  endtask

  // Load coincides with the digit0->digit1 wrap; later data_i changes without load are ignored
  task automatic test_back_to_back();
    do_reset();
    lz_blank_en_i = 1'b0;
    load_now(16'h12AF, 4'h0, 4'h0, 4'h0);
    goto_slot(2);
    n_vec++;
    if (seg_o !== 7'h0E) begin n_err++; $display("FAIL b2b_old got %h want 0e", seg_o); end
    goto_slot(6);
    data_i = 16'h3333;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    data_i = 16'hFFFF;
    goto_slot(8);
    n_vec++;
    if (seg_o !== 7'h7F || an_o !== 4'hF) begin
      n_err++; $display("FAIL b2b_dead got seg=%h an=%h want 7f f", seg_o, an_o);
    end
    goto_slot(10);
    n_vec++;
    if (seg_o !== 7'h30 || an_o !== 4'hD) begin
      n_err++; $display("FAIL b2b_new got seg=%h an=%h want 30 d", seg_o, an_o);
    end
    goto_slot(18);
    n_vec++;
    if (seg_o !== 7'h30 || an_o !== 4'hB) begin
      n_err++; $display("FAIL b2b_hold got seg=%h an=%h want 30 b", seg_o, an_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lz_blank_en_i = 1'b0;
    load_now(16'h12AF, 4'h0, 4'h0, 4'h0);
    goto_slot(20);
    n_vec++;
    if (seg_o !== 7'h24 || an_o !== 4'hB) begin
      n_err++; $display("FAIL mid_pre got seg=%h an=%h want 24 b", seg_o, an_o);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (seg_o !== 7'h7F || an_o !== 4'hF || dp_o !== 1'b1 || frame_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst got seg=%h an=%h dp=%b fr=%b want 7f f 1 0", seg_o, an_o, dp_o,
               frame_o);
    end
    rst = 1'b0;
    cyc = 0;
    goto_slot(2);
    n_vec++;
    if (seg_o !== 7'h40 || an_o !== 4'hE) begin
      n_err++; $display("FAIL mid_d0 got seg=%h an=%h want 40 e", seg_o, an_o);
    end
    goto_slot(10);
    n_vec++;
    if (seg_o !== 7'h40 || an_o !== 4'hD) begin
      n_err++; $display("FAIL mid_d1 got seg=%h an=%h want 40 d", seg_o, an_o);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_lz();
    test_lz_dp();
    test_blank();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
